// File: rtl/hazard_pkg.sv
`default_nettype none
//============================================================================
// Package  : hazard_pkg
// Brief    : Shared encodings and types for the pipeline hazard controller.
// Revision : 1.0 - initial release
//============================================================================
package hazard_pkg;

    localparam int unsigned c_nreg_w = 3;

    localparam logic [1:0] c_st_run    = 2'b00;
    localparam logic [1:0] c_st_drain  = 2'b01;
    localparam logic [1:0] c_st_halted = 2'b10;

    typedef struct packed {
        logic                v;
        logic [c_nreg_w-1:0] sel;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_stage.sv
`default_nettype none
//============================================================================
// Module   : sb_stage
// Brief    : One destination-register scoreboard entry with Rs/Rt comparators.
// Revision : 1.0 - initial release
//============================================================================
module sb_stage
    import hazard_pkg::*;
#(
    parameter int NREG_W   = c_nreg_w,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_v,
    input  logic [NREG_W-1:0] d_sel,
    input  logic [NREG_W-1:0] rs_sel,
    input  logic [NREG_W-1:0] rt_sel,
    output logic              q_v,
    output logic [NREG_W-1:0] q_sel,
    output logic              rs_match,
    output logic              rt_match
);

    logic              r_v;
    logic [NREG_W-1:0] r_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= 1'b0;
            r_sel <= '0;
        end else begin
            r_v   <= d_v;
            r_sel <= d_sel;
        end
    end

    assign q_v   = r_v;
    assign q_sel = r_sel;

    // A stage excluded from checking never reports a match.
    assign rs_match = CHECK_EN && r_v && (r_sel == rs_sel);
    assign rt_match = CHECK_EN && r_v && (r_sel == rt_sel);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage pipeline sequencer: RAW stall, redirect flush, halt drain.
//            Macro HAZARD_CTRL_PERF_EN adds saturating stall/flush/bubble counters.
// Revision : 1.0 - initial release
//============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RF_BYPASS = 1,
    parameter int NREG_W    = c_nreg_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic              dec_rs_used,
    input  logic              dec_rt_used,
    input  logic [NREG_W-1:0] dec_rs,
    input  logic [NREG_W-1:0] dec_rt,
    input  logic              dec_wr_en,
    input  logic [NREG_W-1:0] dec_wr_sel,
    input  logic              dec_redirect,
    input  logic              dec_halt,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic              dump,
    output logic              halted
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_dcnt;
    logic [1:0] w_dcnt_nxt;
    logic       r_rst_q;

    logic              w_d_v      [3];
    logic [NREG_W-1:0] w_d_sel    [3];
    logic              w_q_v      [3];
    logic [NREG_W-1:0] w_q_sel    [3];
    logic              w_rs_match [3];
    logic              w_rt_match [3];

    logic w_live;
    logic w_hazard;

    // Scoreboard chain EX -> MEM -> WB; WB is only checked without RF bypass.
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_d_v[gi]   = ~bubble & dec_valid & dec_wr_en;
            assign w_d_sel[gi] = bubble ? '0 : dec_wr_sel;
        end else begin : g_link
            assign w_d_v[gi]   = w_q_v[gi-1];
            assign w_d_sel[gi] = w_q_sel[gi-1];
        end

        sb_stage #(
            .NREG_W   (NREG_W),
            .CHECK_EN ((gi < 2) || (RF_BYPASS == 0))
        ) u_sb (
            .clk      (clk),
            .rst      (rst),
            .d_v      (w_d_v[gi]),
            .d_sel    (w_d_sel[gi]),
            .rs_sel   (dec_rs),
            .rt_sel   (dec_rt),
            .q_v      (w_q_v[gi]),
            .q_sel    (w_q_sel[gi]),
            .rs_match (w_rs_match[gi]),
            .rt_match (w_rt_match[gi])
        );
    end

    // Decode is ignored in the first cycle out of reset so every output stays low.
    assign w_live   = dec_valid & ~r_rst_q;
    assign w_hazard = w_live &
                      ((dec_rs_used & (w_rs_match[0] | w_rs_match[1] | w_rs_match[2])) |
                       (dec_rt_used & (w_rt_match[0] | w_rt_match[1] | w_rt_match[2])));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_run;
            r_dcnt  <= 2'd0;
            r_rst_q <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_rst_q <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        stall       = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        dump        = 1'b0;
        halted      = 1'b0;
        case (r_state)
            c_st_run: begin
                if (w_hazard) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end else if (w_live && dec_halt) begin
                    // HALT itself proceeds to EX; everything younger is killed.
                    w_state_nxt = c_st_drain;
                    w_dcnt_nxt  = 2'd0;
                    stall       = 1'b1;
                    flush       = 1'b1;
                end else if (w_live && dec_redirect) begin
                    flush = 1'b1;
                end
            end
            c_st_drain: begin
                stall      = 1'b1;
                flush      = 1'b1;
                bubble     = 1'b1;
                w_dcnt_nxt = r_dcnt + 2'd1;
                dump       = (r_dcnt == 2'd1);
                if (r_dcnt == 2'd2) begin
                    w_state_nxt = c_st_halted;
                end
            end
            c_st_halted: begin
                stall  = 1'b1;
                flush  = 1'b1;
                bubble = 1'b1;
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = c_st_run;
                w_dcnt_nxt  = 2'd0;
            end
        endcase
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= 16'd0;
            r_flush_cnt  <= 16'd0;
            r_bubble_cnt <= 16'd0;
        end else if (r_state == c_st_run) begin
            if (stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
            if (bubble && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl (RF_BYPASS=1 and RF_BYPASS=0 copies).
//            HAZARD_CTRL_PERF_EN enables the counter scenarios.
// Revision : 1.0 - initial release
//============================================================================
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic       rsu;
        logic [2:0] rs;
        logic       rtu;
        logic [2:0] rt;
        logic       we;
        logic [2:0] ws;
        logic       rd;
        logic       hl;
    } stim_t;

    // {stall, bubble, flush, dump, halted}
    typedef logic [4:0] exp_t;
    localparam exp_t c_i = 5'b00000;
    localparam exp_t c_s = 5'b11000;
    localparam exp_t c_f = 5'b00100;
    localparam exp_t c_h = 5'b10100;
    localparam exp_t c_d = 5'b11100;
    localparam exp_t c_p = 5'b11110;
    localparam exp_t c_x = 5'b11101;

    logic       clk;
    logic       rst;
    logic       dec_valid, dec_rs_used, dec_rt_used, dec_wr_en, dec_redirect, dec_halt;
    logic [2:0] dec_rs, dec_rt, dec_wr_sel;
    logic       stall_a, bubble_a, flush_a, dump_a, halted_a;
    logic       stall_b, bubble_b, flush_b, dump_b, halted_b;
    exp_t       out_a, out_b;
    exp_t       q_exp_a [$];
    exp_t       q_exp_b [$];
    int         n_checks = 0;
    int         n_fail   = 0;

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt_a, flush_cnt_a, bubble_cnt_a;
    logic [15:0] stall_cnt_b, flush_cnt_b, bubble_cnt_b;
`endif

    assign out_a = {stall_a, bubble_a, flush_a, dump_a, halted_a};
    assign out_b = {stall_b, bubble_b, flush_b, dump_b, halted_b};

    hazard_ctrl #(.RF_BYPASS(1), .NREG_W(3)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs_used(dec_rs_used),
        .dec_rt_used(dec_rt_used), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_wr_en(dec_wr_en),
        .dec_wr_sel(dec_wr_sel), .dec_redirect(dec_redirect), .dec_halt(dec_halt),
        .stall(stall_a), .bubble(bubble_a), .flush(flush_a), .dump(dump_a), .halted(halted_a)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .bubble_cnt(bubble_cnt_a)
`endif
    );

    hazard_ctrl #(.RF_BYPASS(0), .NREG_W(3)) dut0 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs_used(dec_rs_used),
        .dec_rt_used(dec_rt_used), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_wr_en(dec_wr_en),
        .dec_wr_sel(dec_wr_sel), .dec_redirect(dec_redirect), .dec_halt(dec_halt),
        .stall(stall_b), .bubble(bubble_b), .flush(flush_b), .dump(dump_b), .halted(halted_b)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .bubble_cnt(bubble_cnt_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic stim_t nop();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t wr(input logic [2:0] ws);
        stim_t s = '0;
        s.v = 1'b1; s.we = 1'b1; s.ws = ws;
        return s;
    endfunction

    function automatic stim_t rdr(input logic [2:0] rs, input logic [2:0] rt);
        stim_t s = '0;
        s.v = 1'b1; s.rsu = 1'b1; s.rs = rs; s.rtu = 1'b1; s.rt = rt;
        return s;
    endfunction

    function automatic stim_t br(input logic [2:0] rs);
        stim_t s = '0;
        s.v = 1'b1; s.rsu = 1'b1; s.rs = rs; s.rd = 1'b1;
        return s;
    endfunction

    function automatic stim_t hlt();
        stim_t s = '0;
        s.v = 1'b1; s.hl = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst          = s.rst;
        dec_valid    = s.v;
        dec_rs_used  = s.rsu;
        dec_rs       = s.rs;
        dec_rt_used  = s.rtu;
        dec_rt       = s.rt;
        dec_wr_en    = s.we;
        dec_wr_sel   = s.ws;
        dec_redirect = s.rd;
        dec_halt     = s.hl;
    endtask

    task automatic do_reset();
        stim_t s = '0;
        s.rst = 1'b1;
        apply(s);
        @(posedge clk); #1;
        apply(nop());
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        stim_t s [5];
        exp_t  e [5] = '{c_i, c_i, c_i, c_f, c_i};
        exp_t  x;
        s[0] = hlt(); s[0].rd = 1'b1; s[0].rst = 1'b1;
        s[1] = hlt(); s[1].rd = 1'b1;
        s[2] = nop(); s[3] = br(3'd6); s[4] = nop();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]); q_exp_a.push_back(e[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL reset[%0d] got=%b expected=%b", i, out_a, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_raw();
        stim_t s [8];
        exp_t  ea [8] = '{c_i, c_s, c_s, c_i, c_i, c_i, c_i, c_i};
        exp_t  eb [8] = '{c_i, c_s, c_s, c_s, c_i, c_i, c_i, c_i};
        exp_t  x;
        s = '{wr(3'd1), rdr(3'd1, 3'd2), rdr(3'd1, 3'd2), rdr(3'd1, 3'd2),
              rdr(3'd1, 3'd2), nop(), nop(), nop()};
        for (int i = 0; i < 8; i++) begin
            apply(s[i]); q_exp_a.push_back(ea[i]); q_exp_b.push_back(eb[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL raw_bypass1[%0d] got=%b expected=%b", i, out_a, x); end
            x = q_exp_b.pop_front(); n_checks++;
            if (out_b !== x) begin n_fail++; $display("FAIL raw_bypass0[%0d] got=%b expected=%b", i, out_b, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_independent();
        stim_t s [7];
        exp_t  e [7] = '{c_i, c_i, c_i, c_i, c_i, c_i, c_i};
        exp_t  x;
        s = '{wr(3'd2), rdr(3'd3, 3'd4), nop(), wr(3'd2), rdr(3'd2, 3'd2), rdr(3'd2, 3'd2), nop()};
        s[4].v   = 1'b0;
        s[5].rsu = 1'b0; s[5].rtu = 1'b0;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]); q_exp_a.push_back(e[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL independent[%0d] got=%b expected=%b", i, out_a, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_regs();
        stim_t s [12];
        exp_t  e [12] = '{c_i, c_s, c_s, c_i, c_s, c_s, c_i, c_i, c_i, c_s, c_i, c_i};
        exp_t  x;
        stim_t r7;
        r7 = rdr(3'd5, 3'd7); r7.we = 1'b1; r7.ws = 3'd0;
        s = '{wr(3'd7), r7, r7, r7, rdr(3'd0, 3'd6), rdr(3'd0, 3'd6), rdr(3'd0, 3'd6),
              wr(3'd5), nop(), rdr(3'd1, 3'd5), rdr(3'd1, 3'd5), nop()};
        for (int i = 0; i < 12; i++) begin
            apply(s[i]); q_exp_a.push_back(e[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL regs_edge[%0d] got=%b expected=%b", i, out_a, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t s [7];
        exp_t  e [7] = '{c_f, c_i, c_i, c_s, c_s, c_f, c_i};
        exp_t  x;
        s = '{br(3'd6), nop(), wr(3'd4), br(3'd4), br(3'd4), br(3'd4), nop()};
        for (int i = 0; i < 7; i++) begin
            apply(s[i]); q_exp_a.push_back(e[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL branch[%0d] got=%b expected=%b", i, out_a, x); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        stim_t s [9];
        exp_t  e [9] = '{c_h, c_d, c_p, c_d, c_x, c_x, c_x, c_x, c_x};
        exp_t  x;
        s = '{hlt(), br(3'd2), wr(3'd3), hlt(), nop(), br(3'd1), hlt(), wr(3'd1), rdr(3'd1, 3'd1)};
        s[0].rd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            apply(s[i]); q_exp_a.push_back(e[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL halt[%0d] got=%b expected=%b", i, out_a, x); end
            @(posedge clk); #1;
        end
        do_reset();
    endtask

    task automatic test_rst_mid_drain();
        stim_t s [11];
        exp_t  e [11] = '{c_i, c_h, c_d, c_i, c_i, c_i, c_i, c_i, c_s, c_s, c_i};
        exp_t  x;
        s = '{wr(3'd6), hlt(), nop(), nop(), nop(), nop(), nop(),
              wr(3'd1), rdr(3'd1, 3'd2), rdr(3'd1, 3'd2), rdr(3'd1, 3'd2)};
        s[3].rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            apply(s[i]); q_exp_a.push_back(e[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL rst_mid_drain[%0d] got=%b expected=%b", i, out_a, x); end
            @(posedge clk); #1;
        end
        apply(nop());
        @(posedge clk); #1;
    endtask

`ifdef HAZARD_CTRL_PERF_EN
    task automatic test_perf();
        stim_t s [17];
        exp_t  e [17] = '{c_i, c_s, c_s, c_i, c_i, c_i, c_i, c_s, c_i,
                          c_i, c_s, c_s, c_i, c_f, c_i, c_f, c_i};
        exp_t  x;
        s = '{wr(3'd1), rdr(3'd1, 3'd2), rdr(3'd1, 3'd2), rdr(3'd1, 3'd2), nop(),
              wr(3'd3), nop(), rdr(3'd3, 3'd3), rdr(3'd3, 3'd3),
              wr(3'd4), rdr(3'd4, 3'd4), rdr(3'd4, 3'd4), rdr(3'd4, 3'd4),
              br(3'd6), nop(), br(3'd6), nop()};
        do_reset();
        n_checks++;
        if ({stall_cnt_a, flush_cnt_a, bubble_cnt_a} !== 48'd0) begin
            n_fail++; $display("FAIL perf_reset got=%h expected=0", {stall_cnt_a, flush_cnt_a, bubble_cnt_a});
        end
        for (int i = 0; i < 17; i++) begin
            apply(s[i]); q_exp_a.push_back(e[i]);
            @(negedge clk);
            x = q_exp_a.pop_front(); n_checks++;
            if (out_a !== x) begin n_fail++; $display("FAIL perf_seq[%0d] got=%b expected=%b", i, out_a, x); end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({stall_cnt_a, flush_cnt_a, bubble_cnt_a} !== {16'd5, 16'd2, 16'd5}) begin
            n_fail++; $display("FAIL perf_counts got=%0d/%0d/%0d expected=5/2/5", stall_cnt_a, flush_cnt_a, bubble_cnt_a);
        end
        // The HALT cycle itself is in RUN; drain and halted cycles are not counted.
        apply(hlt());
        @(posedge clk); #1;
        apply(nop());
        repeat (7) begin @(posedge clk); #1; end
        n_checks++;
        if ({stall_cnt_a, flush_cnt_a, bubble_cnt_a} !== {16'd6, 16'd3, 16'd5}) begin
            n_fail++; $display("FAIL perf_drain got=%0d/%0d/%0d expected=6/3/5", stall_cnt_a, flush_cnt_a, bubble_cnt_a);
        end
        do_reset();
        apply(br(3'd6));
        repeat (65540) @(posedge clk);
        #1;
        n_checks++;
        if ({stall_cnt_a, flush_cnt_a, bubble_cnt_a} !== {16'd0, 16'hFFFF, 16'd0}) begin
            n_fail++; $display("FAIL perf_saturate got=%h/%h/%h expected=0000/ffff/0000", stall_cnt_a, flush_cnt_a, bubble_cnt_a);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_raw();
        test_independent();
        test_regs();
        test_branch();
        test_halt();
        test_rst_mid_drain();
`ifdef HAZARD_CTRL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
